// File: rtl/half_sum_pkg.sv
// Shared types and the behavioural reference for the half_sum lane array.
// Used by the HALF_SUM_CHECK_EN checker in half_sum.
package half_sum_pkg;

    localparam int MAX_WIDTH = 64;

    typedef struct packed {
        logic c;
        logic s;
    } half_sum_res_t;

    // The reference form: a plain 2-bit add, independent of the gate netlist.
    function automatic half_sum_res_t hs_ref(input logic a, input logic b);
        half_sum_res_t r;
        r = half_sum_res_t'({1'b0, a} + {1'b0, b});
        return r;
    endfunction

endpackage

// File: rtl/half_sum_cell.sv
// One gate-level half-adder lane: s = a ^ b, c = a & b.
module half_sum_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    xor g_xor (s, a, b);
    and g_and (c, a, b);

endmodule

// File: rtl/half_sum.sv
// Vector of independent half adders with optional output registers and a valid strobe.
// Optional self-check against a behavioural reference: define HALF_SUM_CHECK_EN.
module half_sum
    import half_sum_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] qs,
    output logic [WIDTH-1:0] qcout,
    output logic             out_valid,
    output logic             mismatch
);

    logic [WIDTH-1:0] gate_s;
    logic [WIDTH-1:0] gate_c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_sum_cell u_cell (
            .a (a[i]),
            .b (b[i]),
            .s (gate_s[i]),
            .c (gate_c[i])
        );
    end

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0] qs_q;
        logic [WIDTH-1:0] qc_q;
        logic             valid_q;

        // Loading only on in_valid keeps unknown idle inputs out of the registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                qs_q    <= '0;
                qc_q    <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= in_valid;
                if (in_valid) begin
                    qs_q <= gate_s;
                    qc_q <= gate_c;
                end
            end
        end

        assign qs        = qs_q;
        assign qcout     = qc_q;
        assign out_valid = valid_q;
    end else begin : g_comb
        assign qs        = rst_n ? gate_s : '0;
        assign qcout     = rst_n ? gate_c : '0;
        assign out_valid = rst_n & in_valid;
    end

`ifdef HALF_SUM_CHECK_EN
    logic [WIDTH-1:0] ref_s;
    logic [WIDTH-1:0] ref_c;
    logic             mismatch_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ref
        assign {ref_c[i], ref_s[i]} = hs_ref(a[i], b[i]);
    end

    // Sticky until reset so a single bad cycle is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_q <= 1'b0;
        end else if (in_valid && ((ref_s != gate_s) || (ref_c != gate_c))) begin
            mismatch_q <= 1'b1;
        end
    end

    assign mismatch = mismatch_q;
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_half_sum.sv
// Self-checking bench for half_sum: scoreboarded registered lanes, full-adder cell, hold and reset.
module tb_half_sum;

    typedef struct packed {
        logic [7:0] s;
        logic [7:0] c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;

    logic [7:0] qs8, qc8;
    logic       ov8, mm8;
    logic [0:0] qs1, qc1;
    logic       ov1, mm1;

    logic [0:0] fa_a = '0, fa_b = '0, fa_cin = '0;
    logic [0:0] h1_s, h1_c, h2_s, h2_c;
    logic       h1_v, h2_v, h1_m, h2_m;
    logic       fa_valid = 1'b0;

    exp_t sb[$];
    bit   sb_on = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    half_sum #(.WIDTH(8), .REG_OUT(1'b1)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .qs(qs8), .qcout(qc8), .out_valid(ov8), .mismatch(mm8)
    );

    half_sum #(.WIDTH(1), .REG_OUT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a[0:0]), .b(b[0:0]),
        .qs(qs1), .qcout(qc1), .out_valid(ov1), .mismatch(mm1)
    );

    half_sum #(.WIDTH(1), .REG_OUT(1'b0)) fa_h1 (
        .clk(clk), .rst_n(rst_n), .in_valid(fa_valid), .a(fa_a), .b(fa_b),
        .qs(h1_s), .qcout(h1_c), .out_valid(h1_v), .mismatch(h1_m)
    );

    half_sum #(.WIDTH(1), .REG_OUT(1'b0)) fa_h2 (
        .clk(clk), .rst_n(rst_n), .in_valid(h1_v), .a(h1_s), .b(fa_cin),
        .qs(h2_s), .qcout(h2_c), .out_valid(h2_v), .mismatch(h2_m)
    );

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] av, input logic [7:0] bv,
                                 input logic [7:0] es, input logic [7:0] ec);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        a = av;
        b = bv;
        if (v) begin
            e.s = es;
            e.c = ec;
            sb.push_back(e);
        end
    endtask

    // Pop one expected result per valid output.
    always @(negedge clk) begin
        if (sb_on && rst_n) begin
            checkOutput("mismatch8", 64'(mm8), 64'd0);
            if (ov8) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_underflow", 64'(sb.size()), 64'd1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("qs8", 64'(qs8), 64'(e.s));
                    checkOutput("qcout8", 64'(qc8), 64'(e.c));
                    checkOutput("ov1", 64'(ov1), 64'd1);
                    checkOutput("qs1", 64'(qs1), 64'(e.s[0]));
                    checkOutput("qcout1", 64'(qc1), 64'(e.c[0]));
                end
            end
        end
    end

    logic [1:0] t1_exp [4];
    logic [1:0] fa_exp [8];

    initial begin
        logic [7:0] av, bv;
        logic [2:0] idx;
        logic [1:0] tv;
        logic       fa_cout;

        t1_exp = '{2'b00, 2'b01, 2'b01, 2'b10};
        fa_exp = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        // Reset state
        #12;
        checkOutput("rst_qs8", 64'(qs8), 64'd0);
        checkOutput("rst_qcout8", 64'(qc8), 64'd0);
        checkOutput("rst_ov8", 64'(ov8), 64'd0);
        checkOutput("rst_mm8", 64'(mm8), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // T1: single-lane truth table
        for (int i = 0; i < 4; i++) begin
            tv = 2'(i);
            applyStimulus(1'b1, {7'd0, tv[1]}, {7'd0, tv[0]},
                          {7'd0, t1_exp[i][0]}, {7'd0, t1_exp[i][1]});
        end

        // T2: wide patterns
        applyStimulus(1'b1, 8'hFF, 8'h01, 8'hFE, 8'h01);
        applyStimulus(1'b1, 8'hA5, 8'h5A, 8'hFF, 8'h00);

        // Random back-to-back traffic with occasional idle cycles
        for (int i = 0; i < 24; i++) begin
            av = 8'($urandom);
            bv = 8'($urandom);
            applyStimulus((i % 5) != 3, av, bv, av ^ bv, av & bv);
        end

        // T4: hold after in_valid drops
        applyStimulus(1'b1, 8'hFF, 8'hFF, 8'h00, 8'hFF);
        applyStimulus(1'b1, 8'hFF, 8'hFF, 8'h00, 8'hFF);
        applyStimulus(1'b0, 8'h3C, 8'hC3, 8'h00, 8'h00);
        @(negedge clk);
        #1;
        checkOutput("hold_ov8", 64'(ov8), 64'd0);
        checkOutput("hold_qcout8", 64'(qc8), 64'hFF);
        checkOutput("hold_qs8", 64'(qs8), 64'h00);
        checkOutput("hold_qcout1", 64'(qc1), 64'd1);
        checkOutput("hold_qs1", 64'(qs1), 64'd0);
        @(negedge clk);
        #1;
        checkOutput("hold2_qcout8", 64'(qc8), 64'hFF);

        // T5: asynchronous reset between edges
        applyStimulus(1'b1, 8'h0F, 8'h33, 8'h3C, 8'h03);
        @(posedge clk);
        #2;
        checkOutput("pre_rst_qs8", 64'(qs8), 64'h3C);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_qs8", 64'(qs8), 64'd0);
        checkOutput("arst_qcout8", 64'(qc8), 64'd0);
        checkOutput("arst_ov8", 64'(ov8), 64'd0);
        checkOutput("arst_mm8", 64'(mm8), 64'd0);
        checkOutput("arst_qs1", 64'(qs1), 64'd0);
        checkOutput("arst_ov1", 64'(ov1), 64'd0);
        sb.delete();
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        applyStimulus(1'b0, 8'h55, 8'h55, 8'h00, 8'h00);
        @(negedge clk);
        #1;
        checkOutput("post_rst_ov8", 64'(ov8), 64'd0);
        applyStimulus(1'b1, 8'h81, 8'h01, 8'h80, 8'h01);
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        checkOutput("sb_drain", 64'(sb.size()), 64'd0);

        // T3: full adder from two combinational instances
        fa_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            idx = 3'(i);
            fa_a = idx[2];
            fa_b = idx[1];
            fa_cin = idx[0];
            #1;
            fa_cout = h1_c[0] | h2_c[0];
            checkOutput($sformatf("fa_%0d", i), 64'({fa_cout, h2_s[0]}), 64'(fa_exp[i]));
        end
        checkOutput("fa_valid", 64'(h2_v), 64'd1);
        fa_valid = 1'b0;
        #1;
        checkOutput("fa_valid_low", 64'(h2_v), 64'd0);

`ifdef HALF_SUM_CHECK_EN
        // T6: corrupt one gate lane and watch the sticky flag
        sb_on = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        a = 8'h01;
        b = 8'h01;
        force dut1.gate_s = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("chk_mm1_set", 64'(mm1), 64'd1);
        checkOutput("chk_mm8_clean", 64'(mm8), 64'd0);
        release dut1.gate_s;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("chk_mm1_sticky", 64'(mm1), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("chk_mm1_rst", 64'(mm1), 64'd0);
        #2 rst_n = 1'b1;
`else
        checkOutput("mm1_tied", 64'(mm1), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
